// File: rtl/pulse_monitor_x16_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pulse_monitor_x16_if                                    |
// | Purpose  : Signal bundle between the padiwa test-pulse loopback    |
// |            and the pulse monitor. The master drives the pulses and |
// |            the slave (the monitor) returns per-window results.     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface pulse_monitor_x16_if;
   logic        trig_in;
   logic [15:0] chan_in;
   logic        result_valid;
   logic [15:0] hit_mask;
   logic        all_ok;
   logic [15:0] trig_count;
   logic [15:0] error_count;
   logic [7:0]  overlap_count;
   logic [15:0] width_err_mask;

   modport master (
      output trig_in, chan_in,
      input  result_valid, hit_mask, all_ok, trig_count, error_count,
             overlap_count, width_err_mask
   );

   modport slave (
      input  trig_in, chan_in,
      output result_valid, hit_mask, all_ok, trig_count, error_count,
             overlap_count, width_err_mask
   );
endinterface
`default_nettype wire

// File: rtl/pulse_monitor_x16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pulse_monitor_x16                                       |
// | Purpose  : Coincidence checker for the 16-channel test pulser.     |
// |            Each reference pulse opens a WINDOW_LEN-cycle window;   |
// |            channel rising edges inside it form the hit mask, and   |
// |            saturating trigger/error/overlap counters are kept.     |
// | Option   : define PULSE_MONITOR_WIDTH_CHECK_EN to build per-channel|
// |            pulse-width checking against EXP_WIDTH +/- 1.           |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module pulse_monitor_x16 #(
   parameter int WINDOW_LEN = 16,   // 1..255 clk cycles
   parameter int EXP_WIDTH  = 4     // expected channel high time
) (
   input  wire logic          clk,
   input  wire logic          reset,
   pulse_monitor_x16_if.slave mon
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WINDOW = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   localparam logic [7:0] c_win_load = 8'(WINDOW_LEN - 1);

   // synchroniser chains: s1/s2 resolve metastability, s3 is the edge reference
   logic        trig_s1_q, trig_s2_q, trig_s3_q;
   logic [15:0] chan_s1_q, chan_s2_q, chan_s3_q;

   state_t      state_q, state_d;
   logic [7:0]  win_cnt_q, win_cnt_d;
   logic [15:0] hit_acc_q, hit_acc_d;
   logic [15:0] werr_acc_q, werr_acc_d;

   logic [15:0] hit_mask_q;
   logic [15:0] werr_mask_q;
   logic        all_ok_q;
   logic [15:0] trig_cnt_q;
   logic [15:0] err_cnt_q;
   logic [7:0]  ovl_cnt_q;

   logic        w_trig_rise;
   logic [15:0] w_chan_rise;
   logic        w_close;
   logic        w_overlap;
   logic [15:0] w_hit_next;
   logic [15:0] w_werr_evt;
   logic [15:0] w_werr_next;
   logic        w_all_ok_d;

   // bring the asynchronous pulses into the clk domain
   always_ff @(posedge clk) begin
      if (reset) begin
         trig_s1_q <= 1'b0;
         trig_s2_q <= 1'b0;
         trig_s3_q <= 1'b0;
         chan_s1_q <= '0;
         chan_s2_q <= '0;
         chan_s3_q <= '0;
      end else begin
         trig_s1_q <= mon.trig_in;
         trig_s2_q <= trig_s1_q;
         trig_s3_q <= trig_s2_q;
         chan_s1_q <= mon.chan_in;
         chan_s2_q <= chan_s1_q;
         chan_s3_q <= chan_s2_q;
      end
   end

   assign w_trig_rise = trig_s2_q & ~trig_s3_q;
   assign w_chan_rise = chan_s2_q & ~chan_s3_q;

   // last cycle of the window: outputs are loaded on this edge so they are
   // already valid while the REPORT strobe is high
   assign w_close   = (state_q == ST_WINDOW) && (win_cnt_q == 8'd0);
   assign w_overlap = w_trig_rise && (state_q != ST_IDLE);

   // accumulators start from zero in the opening (IDLE) cycle so rises that
   // coincide with the trigger are kept
   assign w_hit_next  = ((state_q == ST_WINDOW) ? hit_acc_q : 16'h0000) | w_chan_rise;
   assign w_werr_next = ((state_q == ST_WINDOW) ? werr_acc_q : 16'h0000) | w_werr_evt;
   assign w_all_ok_d  = (w_hit_next == 16'hFFFF) && (w_werr_next == 16'h0000);

`ifdef PULSE_MONITOR_WIDTH_CHECK_EN
   logic [15:0] w_chan_fall;
   logic [15:0] w_bad_width;
   logic [15:0] w_width_eval;

   assign w_chan_fall = chan_s3_q & ~chan_s2_q;

   for (genvar g = 0; g < 16; g++) begin : g_width
      logic [3:0] wcnt_q, wcnt_d;

      // high-time so far including this cycle; equals the full width on the
      // falling-edge cycle because the count does not move while s2 is low
      always_comb begin
         wcnt_d = wcnt_q;
         if (w_chan_rise[g]) begin
            wcnt_d = 4'd1;
         end else if (chan_s2_q[g] && (wcnt_q != 4'hF)) begin
            wcnt_d = wcnt_q + 4'd1;
         end
      end

      // per-channel high-time counter
      always_ff @(posedge clk) begin
         if (reset) begin
            wcnt_q <= 4'd0;
         end else begin
            wcnt_q <= wcnt_d;
         end
      end

      assign w_bad_width[g] = (int'(wcnt_d) < (EXP_WIDTH - 1)) ||
                              (int'(wcnt_d) > (EXP_WIDTH + 1));
   end

   // judge a pulse when it ends, or at window close if it is still high
   assign w_width_eval = w_chan_fall | ({16{w_close}} & chan_s2_q);
   assign w_werr_evt   = w_width_eval & w_hit_next & w_bad_width;
`else
   // EXP_WIDTH has no effect when width checking is not built
   localparam logic [15:0] c_werr_off = (EXP_WIDTH > 0) ? 16'h0000 : 16'h0000;
   assign w_werr_evt = c_werr_off;
`endif

   // window sequencing and accumulator next-state
   always_comb begin
      state_d    = state_q;
      win_cnt_d  = win_cnt_q;
      hit_acc_d  = hit_acc_q;
      werr_acc_d = werr_acc_q;
      case (state_q)
         ST_IDLE: begin
            if (w_trig_rise) begin
               state_d    = ST_WINDOW;
               win_cnt_d  = c_win_load;
               hit_acc_d  = w_hit_next;
               werr_acc_d = w_werr_next;
            end
         end
         ST_WINDOW: begin
            hit_acc_d  = w_hit_next;
            werr_acc_d = w_werr_next;
            if (win_cnt_q == 8'd0) begin
               state_d = ST_REPORT;
            end else begin
               win_cnt_d = win_cnt_q - 8'd1;
            end
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, accumulators, result registers and saturating counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         win_cnt_q   <= 8'd0;
         hit_acc_q   <= '0;
         werr_acc_q  <= '0;
         hit_mask_q  <= '0;
         werr_mask_q <= '0;
         all_ok_q    <= 1'b0;
         trig_cnt_q  <= '0;
         err_cnt_q   <= '0;
         ovl_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         win_cnt_q  <= win_cnt_d;
         hit_acc_q  <= hit_acc_d;
         werr_acc_q <= werr_acc_d;
         if (w_overlap && (ovl_cnt_q != 8'hFF)) begin
            ovl_cnt_q <= ovl_cnt_q + 8'd1;
         end
         if (w_close) begin
            hit_mask_q  <= w_hit_next;
            werr_mask_q <= w_werr_next;
            all_ok_q    <= w_all_ok_d;
            if (trig_cnt_q != 16'hFFFF) begin
               trig_cnt_q <= trig_cnt_q + 16'd1;
            end
            if (!w_all_ok_d && (err_cnt_q != 16'hFFFF)) begin
               err_cnt_q <= err_cnt_q + 16'd1;
            end
         end
      end
   end

   assign mon.result_valid   = (state_q == ST_REPORT);
   assign mon.hit_mask       = hit_mask_q;
   assign mon.all_ok         = all_ok_q;
   assign mon.trig_count     = trig_cnt_q;
   assign mon.error_count    = err_cnt_q;
   assign mon.overlap_count  = ovl_cnt_q;
   assign mon.width_err_mask = werr_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_monitor_x16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_pulse_monitor_x16                                    |
// | Purpose  : Self-checking bench for pulse_monitor_x16: table of     |
// |            pulse patterns plus hand-written corner sequences; the  |
// |            expected results go through a scoreboard queue.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_pulse_monitor_x16;

   localparam int c_window_len = 16;

   typedef struct {
      logic [15:0] mask;        // channels that pulse
      int          dly;         // channel pulse start, cycles after trig_in
      int          wid;         // normal channel pulse width
      logic [15:0] lmask;       // channels using lwid instead
      int          lwid;
      int          t2;          // second trig_in start (0 = none)
      logic [15:0] exp_hit;
      logic [15:0] exp_werr_wc; // expected width errors with checking built
   } vec_t;

   typedef struct {
      int          id;
      logic [15:0] hit;
      logic        ok;
      logic [15:0] werr;
      logic [15:0] tc;
      logic [15:0] ec;
      logic [7:0]  oc;
      int          cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   total;
   int   bad;
   int   m_tc, m_ec, m_oc;
   exp_t sbq[$];
   exp_t m_e;
   vec_t vecs[12];

   pulse_monitor_x16_if mon_if ();

   pulse_monitor_x16 #(.WINDOW_LEN(c_window_len), .EXP_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (mon_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] eff_werr(input logic [15:0] w);
`ifdef PULSE_MONITOR_WIDTH_CHECK_EN
      return w;
`else
      return (w & 16'h0000);
`endif
   endfunction

   task automatic push_exp(input int id, input logic [15:0] hit, input logic [15:0] werr,
                           input int e0, input int ovl);
      exp_t e;
      e.id   = id;
      e.hit  = hit;
      e.werr = werr;
      e.ok   = (hit == 16'hFFFF) && (werr == 16'h0000);
      if (m_tc < 16'hFFFF) m_tc++;
      if (!e.ok && m_ec < 16'hFFFF) m_ec++;
      m_oc += ovl;
      e.tc  = 16'(m_tc);
      e.ec  = 16'(m_ec);
      e.oc  = 8'(m_oc);
      e.cyc = e0 + 2 + c_window_len;
      sbq.push_back(e);
   endtask

   task automatic drain(input int id, input int budget);
      for (int i = 0; i < budget && sbq.size() != 0; i++) @(negedge clk);
      chk($sformatf("v%0d_pending", id), 32'(sbq.size()), 32'd0);
      sbq.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(mon_if.result_valid), 32'd0);
      chk({tag, "_hit"},   32'(mon_if.hit_mask), 32'd0);
      chk({tag, "_ok"},    32'(mon_if.all_ok), 32'd0);
      chk({tag, "_tc"},    32'(mon_if.trig_count), 32'd0);
      chk({tag, "_ec"},    32'(mon_if.error_count), 32'd0);
      chk({tag, "_oc"},    32'(mon_if.overlap_count), 32'd0);
      chk({tag, "_werr"},  32'(mon_if.width_err_mask), 32'd0);
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int          span;
      int          e0;
      int          w;
      logic [15:0] m;
      logic [15:0] lm;
      logic [15:0] ch;
      m    = v.mask;
      lm   = v.lmask;
      span = v.dly + ((v.lwid > v.wid) ? v.lwid : v.wid);
      if (v.t2 + 4 > span) span = v.t2 + 4;
      span = span + 1;
      @(negedge clk);
      e0 = cyc + 1;
      push_exp(id, v.exp_hit, eff_werr(v.exp_werr_wc), e0, (v.t2 > 0) ? 1 : 0);
      for (int c = 0; c < span; c++) begin
         mon_if.trig_in = (c < 4) || ((v.t2 > 0) && (c >= v.t2) && (c < v.t2 + 4));
         ch = '0;
         for (int b = 0; b < 16; b++) begin
            w     = lm[b] ? v.lwid : v.wid;
            ch[b] = m[b] && (c >= v.dly) && (c < v.dly + w);
         end
         mon_if.chan_in = ch;
         @(negedge clk);
      end
      mon_if.trig_in = 1'b0;
      mon_if.chan_in = '0;
      drain(id, 40);
      repeat (6) @(negedge clk);
   endtask

   // scoreboard consumer: every result strobe must match the queue head
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (mon_if.result_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
               m_e = sbq.pop_front();
               chk($sformatf("v%0d_latency", m_e.id), 32'(cyc), 32'(m_e.cyc));
               chk($sformatf("v%0d_hit", m_e.id), 32'(mon_if.hit_mask), 32'(m_e.hit));
               chk($sformatf("v%0d_ok", m_e.id), 32'(mon_if.all_ok), 32'(m_e.ok));
               chk($sformatf("v%0d_werr", m_e.id), 32'(mon_if.width_err_mask), 32'(m_e.werr));
               chk($sformatf("v%0d_tc", m_e.id), 32'(mon_if.trig_count), 32'(m_e.tc));
               chk($sformatf("v%0d_ec", m_e.id), 32'(mon_if.error_count), 32'(m_e.ec));
               chk($sformatf("v%0d_oc", m_e.id), 32'(mon_if.overlap_count), 32'(m_e.oc));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      total = 0;
      bad   = 0;
      m_tc  = 0;
      m_ec  = 0;
      m_oc  = 0;
      //            mask      dly wid lmask     lwid t2  exp_hit   exp_werr_wc
      vecs[0]  = '{16'hFFFF, 0,  4, 16'h0000, 0,   0, 16'hFFFF, 16'h0000};
      vecs[1]  = '{16'hEFDF, 0,  4, 16'h0000, 0,   0, 16'hEFDF, 16'h0000};
      vecs[2]  = '{16'hFFFF, 10, 4, 16'h0000, 0,   0, 16'hFFFF, 16'h0000};
      vecs[3]  = '{16'hFFFF, 20, 4, 16'h0000, 0,   0, 16'h0000, 16'h0000};
      vecs[4]  = '{16'hFFFF, 16, 4, 16'h0000, 0,   0, 16'hFFFF, 16'hFFFF};
      vecs[5]  = '{16'hFFFF, 17, 4, 16'h0000, 0,   0, 16'h0000, 16'h0000};
      vecs[6]  = '{16'hFFFF, 0,  4, 16'h0008, 8,   0, 16'hFFFF, 16'h0008};
      vecs[7]  = '{16'hFFFF, 0,  3, 16'h0000, 0,   0, 16'hFFFF, 16'h0000};
      vecs[8]  = '{16'hFFFF, 0,  5, 16'h0000, 0,   0, 16'hFFFF, 16'h0000};
      vecs[9]  = '{16'hFFFF, 0,  2, 16'h0000, 0,   0, 16'hFFFF, 16'hFFFF};
      vecs[10] = '{16'hFFFF, 0,  6, 16'h0000, 0,   0, 16'hFFFF, 16'hFFFF};
      vecs[11] = '{16'h00A5, 5,  4, 16'h0000, 0,   8, 16'h00A5, 16'h0000};

      mon_if.trig_in = 1'b0;
      mon_if.chan_in = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero("reset");

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // one channel pulsing twice in a window is a single hit
      @(negedge clk);
      e0 = cyc + 1;
      push_exp(100, 16'h0001, 16'h0000, e0, 0);
      for (int c = 0; c < 16; c++) begin
         mon_if.trig_in = (c < 4);
         mon_if.chan_in = (((c >= 2) && (c < 6)) || ((c >= 9) && (c < 13))) ? 16'h0001 : 16'h0000;
         @(negedge clk);
      end
      mon_if.trig_in = 1'b0;
      mon_if.chan_in = '0;
      drain(100, 40);
      repeat (6) @(negedge clk);

      // channels held high across the whole window give no hit
      mon_if.chan_in = 16'hFFFF;
      repeat (5) @(negedge clk);
      e0 = cyc + 1;
      push_exp(101, 16'h0000, 16'h0000, e0, 0);
      for (int c = 0; c < 25; c++) begin
         mon_if.trig_in = (c < 4);
         @(negedge clk);
      end
      mon_if.trig_in = 1'b0;
      mon_if.chan_in = '0;
      drain(101, 40);
      repeat (6) @(negedge clk);

      // reset in the middle of a window: no result, everything cleared
      mon_if.trig_in = 1'b1;
      mon_if.chan_in = 16'hFFFF;
      repeat (4) @(negedge clk);
      mon_if.trig_in = 1'b0;
      mon_if.chan_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_tc = 0;
      m_ec = 0;
      m_oc = 0;
      @(negedge clk);
      check_zero("midrst");
      repeat (30) @(negedge clk);
      chk("midrst_no_result", 32'(mon_if.trig_count), 32'd0);

      // normal operation resumes after the abort
      run_vec(200, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
